// File: rtl/csr_pkg.sv
// Shared FSM state encoding and width helpers for the CSR stream encoder.
package csr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    PTR,
    EMIT,
    DONE
  } csr_state_t;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/csr_row_compactor.sv
// One tile row's compacted non-zero list: appends {value, column} during the scan
// and serves entries back by slot index while the stream is emitted.
module csr_row_compactor #(
  parameter int COLS   = 6,
  parameter int DATA_W = 8,
  parameter int COL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [COL_W-1:0]  rd_slot,
  output logic [DATA_W-1:0] rd_data,
  output logic [COL_W-1:0]  rd_col,
  output logic [COL_W:0]    count
);

  localparam logic [COL_W:0] MAX_CNT = (COL_W + 1)'(COLS);

  logic [DATA_W-1:0] slot_data [COLS];
  logic [COL_W-1:0]  slot_col  [COLS];
  logic              can_write;

  assign can_write = wr_en && (count < MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (can_write) begin
      count <= count + 1'b1;
    end
  end

  // Slot storage needs no reset: only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (can_write) begin
      slot_data[count[COL_W-1:0]] <= wr_data;
      slot_col[count[COL_W-1:0]]  <= wr_col;
    end
  end

  assign rd_data = slot_data[rd_slot];
  assign rd_col  = slot_col[rd_slot];

endmodule

// File: rtl/csr_stream_encoder.sv
// Captures a dense ROWS x COLS tile, compacts each row's non-zeros in parallel and
// streams them as (value, column, row) beats in CSR order with a published row-pointer array.
module csr_stream_encoder
  import csr_pkg::*;
#(
  parameter  int ROWS   = 6,
  parameter  int COLS   = 6,
  parameter  int DATA_W = 8,
  localparam int COL_W  = idx_w(COLS),
  localparam int ROW_W  = idx_w(ROWS),
  localparam int PTR_W  = ptr_w(ROWS, COLS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROWS*COLS*DATA_W-1:0] mat_in,
  input  logic [ROW_W:0]              n_rows,
  input  logic [COL_W:0]              n_cols,
  output logic                        busy,
  output logic [(ROWS+1)*PTR_W-1:0]   row_ptr,
  output logic                        ptr_valid,
  output logic [PTR_W-1:0]            nz_count,
  output logic                        empty,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [COL_W-1:0]            out_col,
  output logic [ROW_W-1:0]            out_row,
  output logic                        out_last,
  output logic                        done
);

  localparam int             NEL      = ROWS * COLS;
  localparam logic [ROW_W:0] ROWS_MAX = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0] COLS_MAX = (COL_W + 1)'(COLS);

  csr_state_t              state;
  logic [NEL*DATA_W-1:0]   mat_q;
  logic [ROW_W:0]          n_rows_q;
  logic [COL_W:0]          n_cols_q;
  logic [COL_W:0]          col_cnt;
  logic [ROW_W-1:0]        emit_row;
  logic [COL_W:0]          emit_slot;
  logic [PTR_W-1:0]        beats_loaded;

  logic [DATA_W-1:0]       elem     [ROWS][COLS];
  logic [DATA_W-1:0]       row_data [ROWS];
  logic [COL_W-1:0]        row_col  [ROWS];
  logic [COL_W:0]          row_cnt  [ROWS];
  logic [ROWS:0][PTR_W-1:0] ptr_sum;
  logic [PTR_W-1:0]        nz_sum;

  logic [COL_W-1:0]        scan_col;
  logic                    scan_en;
  logic                    clear_rows;
  logic [COL_W:0]          sel_cnt;
  logic [DATA_W-1:0]       sel_data;
  logic [COL_W-1:0]        sel_col;
  logic                    slot_free;
  logic                    engine_on;
  logic                    have_beat;
  logic                    accept;

  assign scan_col   = col_cnt[COL_W-1:0];
  assign scan_en    = (state == SCAN);
  assign clear_rows = (state == LOAD);

  // Row r, column c of the captured tile; r0c0 sits in the most significant element.
  for (genvar r = 0; r < ROWS; r++) begin : g_elem_r
    for (genvar c = 0; c < COLS; c++) begin : g_elem_c
      assign elem[r][c] = mat_q[(NEL-1-(r*COLS+c))*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [ROW_W:0] ROW_ID = (ROW_W + 1)'(r);
    logic row_wr;

    assign row_wr = scan_en && (ROW_ID < n_rows_q) && (|elem[r][scan_col]);

    csr_row_compactor #(
      .COLS   (COLS),
      .DATA_W (DATA_W),
      .COL_W  (COL_W)
    ) u_row (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_rows),
      .wr_en   (row_wr),
      .wr_data (elem[r][scan_col]),
      .wr_col  (scan_col),
      .rd_slot (emit_slot[COL_W-1:0]),
      .rd_data (row_data[r]),
      .rd_col  (row_col[r]),
      .count   (row_cnt[r])
    );
  end

  always_comb begin
    logic [PTR_W-1:0] acc;
    acc     = '0;
    ptr_sum = '0;
    for (int i = 0; i < ROWS; i++) begin
      acc          = acc + PTR_W'(row_cnt[i]);
      ptr_sum[i+1] = acc;
    end
  end

  assign nz_sum = ptr_sum[ROWS];

  // The emit engine also runs during PTR so the first beat is ready on entry to EMIT.
  assign sel_cnt   = row_cnt[emit_row];
  assign sel_data  = row_data[emit_row];
  assign sel_col   = row_col[emit_row];
  assign slot_free = !out_valid || out_ready;
  assign engine_on = ((state == PTR) || (state == EMIT)) && (beats_loaded != nz_sum) && slot_free;
  assign have_beat = emit_slot < sel_cnt;
  assign accept    = (state == EMIT) && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mat_q        <= '0;
      n_rows_q     <= '0;
      n_cols_q     <= '0;
      col_cnt      <= '0;
      emit_row     <= '0;
      emit_slot    <= '0;
      beats_loaded <= '0;
      busy         <= 1'b0;
      row_ptr      <= '0;
      ptr_valid    <= 1'b0;
      nz_count     <= '0;
      empty        <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_col      <= '0;
      out_row      <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mat_q     <= mat_in;
            n_rows_q  <= (n_rows > ROWS_MAX) ? ROWS_MAX : n_rows;
            n_cols_q  <= (n_cols > COLS_MAX) ? COLS_MAX : n_cols;
            busy      <= 1'b1;
            ptr_valid <= 1'b0;
            empty     <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          col_cnt      <= '0;
          emit_row     <= '0;
          emit_slot    <= '0;
          beats_loaded <= '0;
          state        <= ((n_rows_q == '0) || (n_cols_q == '0)) ? PTR : SCAN;
        end
        SCAN: begin
          col_cnt <= col_cnt + 1'b1;
          if (col_cnt + 1'b1 == n_cols_q) begin
            state <= PTR;
          end
        end
        PTR: begin
          row_ptr   <= ptr_sum;
          nz_count  <= nz_sum;
          ptr_valid <= 1'b1;
          empty     <= (nz_sum == '0);
          if (nz_sum == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Loading a new beat overrides the out_valid clear from an accepted handshake.
      if (engine_on) begin
        if (have_beat) begin
          out_valid    <= 1'b1;
          out_data     <= sel_data;
          out_col      <= sel_col;
          out_row      <= emit_row;
          out_last     <= (beats_loaded + 1'b1 == nz_sum);
          beats_loaded <= beats_loaded + 1'b1;
          if (emit_slot + 1'b1 == sel_cnt) begin
            emit_row  <= emit_row + 1'b1;
            emit_slot <= '0;
          end else begin
            emit_slot <= emit_slot + 1'b1;
          end
        end else begin
          emit_row  <= emit_row + 1'b1;
          emit_slot <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_stream_encoder.sv
// Directed bench for csr_stream_encoder (6x6, 8-bit): pointer array, beat stream,
// latency, backpressure hold, clamping, zero-size tiles and mid-stream reset.
module tb_csr_stream_encoder;

  localparam int ROWS   = 6;
  localparam int COLS   = 6;
  localparam int DATA_W = 8;
  localparam int COL_W  = 3;
  localparam int ROW_W  = 3;
  localparam int PTR_W  = 6;

  logic                        clk;
  logic                        rst;
  logic                        start;
  logic [ROWS*COLS*DATA_W-1:0] mat_in;
  logic [ROW_W:0]              n_rows;
  logic [COL_W:0]              n_cols;
  logic                        busy;
  logic [(ROWS+1)*PTR_W-1:0]   row_ptr;
  logic                        ptr_valid;
  logic [PTR_W-1:0]            nz_count;
  logic                        empty;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [COL_W-1:0]            out_col;
  logic [ROW_W-1:0]            out_row;
  logic                        out_last;
  logic                        done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tile [6][6];
  logic [14:0] beatQ[$];
  logic [14:0] expQ[$];
  int          doneCycle;
  int          firstValid;

  csr_stream_encoder #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_in    (mat_in),
    .n_rows    (n_rows),
    .n_cols    (n_cols),
    .busy      (busy),
    .row_ptr   (row_ptr),
    .ptr_valid (ptr_valid),
    .nz_count  (nz_count),
    .empty     (empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [14:0] mkBeat(input int d, input int c, input int r, input bit l);
    return {8'(d), 3'(c), 3'(r), l};
  endfunction

  function automatic logic [14:0] curBeat();
    return {out_data, out_col, out_row, out_last};
  endfunction

  function automatic logic [41:0] ptrOf(input int p0, input int p1, input int p2, input int p3,
                                        input int p4, input int p5, input int p6);
    return {6'(p6), 6'(p5), 6'(p4), 6'(p3), 6'(p2), 6'(p1), 6'(p0)};
  endfunction

  function automatic logic [287:0] packTile();
    logic [287:0] m;
    m = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        m[(35-(r*6+c))*8 +: 8] = tile[r][c];
    return m;
  endfunction

  task automatic clearTile();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        tile[r][c] = 8'h00;
  endtask

  task automatic denseTile();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        tile[r][c] = 8'(r*6 + c + 1);
  endtask

  // Leaves the bench at the negedge of the first cycle after start is sampled.
  task automatic applyStimulus(input int nr, input int nc);
    @(negedge clk);
    mat_in = packTile();
    n_rows = 4'(nr);
    n_cols = 4'(nc);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Cycle 1 is the cycle right after start is sampled; stops at the negedge where done is seen.
  task automatic runTile(input bit randReady, input int budget);
    logic [14:0] heldBeat;
    bit          stalled;
    beatQ.delete();
    doneCycle  = -1;
    firstValid = -1;
    stalled    = 1'b0;
    heldBeat   = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) checkOutput("stall_hold", {48'd0, out_valid, curBeat()}, {48'd0, 1'b1, heldBeat});
      if (out_valid) begin
        if (firstValid < 0) firstValid = cyc;
        if (out_ready) begin
          beatQ.push_back(curBeat());
          stalled = 1'b0;
        end else begin
          heldBeat = curBeat();
          stalled  = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        doneCycle = cyc;
        break;
      end
      @(negedge clk);
    end
    if (doneCycle < 0) checkOutput("done_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic checkBeats(input string tag);
    checkOutput({tag, "_beat_count"}, 64'(beatQ.size()), 64'(expQ.size()));
    for (int i = 0; i < beatQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), 64'(beatQ[i]), 64'(expQ[i]));
  endtask

  initial begin
    int activity;
    rst       = 1'b1;
    start     = 1'b0;
    mat_in    = '0;
    n_rows    = '0;
    n_cols    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_ptr_valid", 64'(ptr_valid), 64'd0);
    checkOutput("rst_empty",     64'(empty),     64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last",  64'(out_last),  64'd0);
    checkOutput("rst_done",      64'(done),      64'd0);
    checkOutput("rst_row_ptr",   64'(row_ptr),   64'd0);
    checkOutput("rst_nz_count",  64'(nz_count),  64'd0);
    checkOutput("rst_out_beat",  64'(curBeat()), 64'd0);
    rst = 1'b0;

    $display("[TB] identity x5, full size");
    clearTile();
    for (int i = 0; i < 6; i++) tile[i][i] = 8'd5;
    applyStimulus(6, 6);
    checkOutput("id_busy", 64'(busy), 64'd1);
    runTile(1'b0, 60);
    expQ.delete();
    for (int r = 0; r < 6; r++) expQ.push_back(mkBeat(5, r, r, r == 5));
    checkBeats("id");
    checkOutput("id_first_beat_cycle", 64'(firstValid), 64'd9);
    checkOutput("id_done_cycle", 64'(doneCycle), 64'd15);
    checkOutput("id_row_ptr", 64'(row_ptr), 64'(ptrOf(0, 1, 2, 3, 4, 5, 6)));
    checkOutput("id_nz_count", 64'(nz_count), 64'd6);
    checkOutput("id_empty", 64'(empty), 64'd0);
    checkOutput("id_ptr_valid", 64'(ptr_valid), 64'd1);

    $display("[TB] all-zero tile, then start during DONE");
    clearTile();
    applyStimulus(6, 6);
    runTile(1'b0, 60);
    checkOutput("zero_beat_count", 64'(beatQ.size()), 64'd0);
    checkOutput("zero_no_valid", 64'(firstValid), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("zero_done_cycle", 64'(doneCycle), 64'd9);
    checkOutput("zero_empty", 64'(empty), 64'd1);
    checkOutput("zero_nz_count", 64'(nz_count), 64'd0);
    checkOutput("zero_row_ptr", 64'(row_ptr), 64'd0);
    denseTile();
    mat_in = packTile();
    n_rows = 4'd6;
    n_cols = 4'd6;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    checkOutput("done_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("done_start_busy2", 64'(busy), 64'd0);
    checkOutput("done_start_ptr_valid", 64'(ptr_valid), 64'd1);
    checkOutput("done_start_empty", 64'(empty), 64'd1);

    $display("[TB] row 2 only");
    clearTile();
    for (int c = 0; c < 6; c++) tile[2][c] = 8'(c + 1);
    applyStimulus(6, 6);
    runTile(1'b0, 60);
    expQ.delete();
    for (int c = 0; c < 6; c++) expQ.push_back(mkBeat(c + 1, c, 2, c == 5));
    checkBeats("row2");
    checkOutput("row2_first_beat_cycle", 64'(firstValid), 64'd11);
    checkOutput("row2_row_ptr", 64'(row_ptr), 64'(ptrOf(0, 0, 0, 6, 6, 6, 6)));
    checkOutput("row2_nz_count", 64'(nz_count), 64'd6);

    $display("[TB] dense tile, random backpressure, oversized n_rows/n_cols");
    denseTile();
    applyStimulus(15, 7);
    runTile(1'b1, 600);
    expQ.delete();
    for (int i = 0; i < 36; i++) expQ.push_back(mkBeat(i + 1, i % 6, i / 6, i == 35));
    checkBeats("dense");
    checkOutput("dense_row_ptr", 64'(row_ptr), 64'(ptrOf(0, 6, 12, 18, 24, 30, 36)));
    checkOutput("dense_nz_count", 64'(nz_count), 64'd36);

    $display("[TB] dense tile, n_rows=3 n_cols=2");
    applyStimulus(3, 2);
    runTile(1'b0, 60);
    expQ.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        expQ.push_back(mkBeat(r*6 + c + 1, c, r, (r == 2) && (c == 1)));
    checkBeats("sub");
    checkOutput("sub_row_ptr", 64'(row_ptr), 64'(ptrOf(0, 2, 4, 6, 6, 6, 6)));
    checkOutput("sub_nz_count", 64'(nz_count), 64'd6);
    checkOutput("sub_done_cycle", 64'(doneCycle), 64'd11);

    $display("[TB] dense tile, n_cols=0");
    applyStimulus(6, 0);
    runTile(1'b0, 30);
    checkOutput("ncol0_beat_count", 64'(beatQ.size()), 64'd0);
    checkOutput("ncol0_done_cycle", 64'(doneCycle), 64'd3);
    checkOutput("ncol0_empty", 64'(empty), 64'd1);
    checkOutput("ncol0_nz_count", 64'(nz_count), 64'd0);

    $display("[TB] reset during EMIT");
    clearTile();
    for (int i = 0; i < 6; i++) tile[i][i] = 8'd5;
    out_ready = 1'b0;
    applyStimulus(6, 6);
    activity = 0;
    for (int cyc = 1; cyc <= 30 && !out_valid; cyc++) @(negedge clk);
    checkOutput("mid_valid_seen", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_out_beat", 64'(curBeat()), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_ptr_valid", 64'(ptr_valid), 64'd0);
    checkOutput("mid_rst_row_ptr", 64'(row_ptr), 64'd0);
    checkOutput("mid_rst_nz_count", 64'(nz_count), 64'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (out_valid || done) activity++;
    end
    checkOutput("mid_rst_quiet", 64'(activity), 64'd0);
    clearTile();
    for (int c = 0; c < 6; c++) tile[2][c] = 8'(c + 1);
    applyStimulus(6, 6);
    runTile(1'b0, 60);
    expQ.delete();
    for (int c = 0; c < 6; c++) expQ.push_back(mkBeat(c + 1, c, 2, c == 5));
    checkBeats("post_rst");
    checkOutput("post_rst_row_ptr", 64'(row_ptr), 64'(ptrOf(0, 0, 0, 6, 6, 6, 6)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
